// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the SCC core data port. It accepts one
//   read or write request at a time against an internal word-addressed RAM,
//   inserts a configurable number of wait states, and then returns a
//   one-cycle response strobe.
//
//   Ports
//     clk         single clock, rising edge
//     reset       synchronous, active-low
//     data_addr   byte address from the core (must be word aligned)
//     data_out    write data from the core
//     data_read   read request, sampled only in IDLE
//     data_write  write request, sampled only in IDLE
//     data_in     read data to the core, held until the next read response
//     data_valid  one-cycle response strobe (reads, writes and faults)
//     data_busy   access in flight; requests are dropped while high
//     addr_fault  request was rejected (misaligned, out of range, rd+wr)
//
//   Build option
//     DMEM_STICKY_FAULT_EN  when defined, addr_fault latches on the first
//                           fault and stays high until reset; otherwise it
//                           pulses with the faulting response's data_valid.
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_valid,
  output logic        data_busy,
  output logic        addr_fault
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN    = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  flt_q, flt_d;
  logic [31:0]           data_q, data_d;
  logic                  mem_we;

  logic [31:0] mem_q [DEPTH];

  // Request decode. The subtraction wraps modulo 2^32; an address below
  // BASE_ADDR is rejected explicitly so a wrapped offset never aliases.
  logic [31:0]           off;
  logic                  req, in_range, req_fault;
  logic [DEPTH_LOG2-1:0] req_idx;

  always_comb begin
    off       = data_addr - BASE_ADDR;
    req       = data_read | data_write;
    in_range  = (data_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    req_fault = (|data_addr[1:0]) | ~in_range | (data_read & data_write);
    req_idx   = off[DEPTH_LOG2+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          wdata_d = data_out;
          wr_d    = data_write;
          flt_d   = req_fault;
          cnt_d   = WS_INIT;
          if (req_fault) begin
            state_d = S_RESP;
          end else if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            if (!data_write) data_d = mem_q[req_idx];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          // Read data is captured on entry to RESP so it is valid with data_valid.
          if (!wr_q) data_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        // Writes commit on the edge leaving RESP, so a reset anywhere in the
        // access (including the RESP cycle) discards them.
        mem_we  = wr_q & ~flt_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      flt_q   <= flt_d;
      data_q  <= data_d;
    end
  end

  // RAM contents survive reset; only the commit is gated.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign data_in    = data_q;
  assign data_valid = (state_q == S_RESP);
  assign data_busy  = (state_q != S_IDLE);

`ifdef DMEM_STICKY_FAULT_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q | ((state_q == S_IDLE) & req & req_fault);
  end

  always_ff @(posedge clk) begin
    if (!reset) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign addr_fault = sticky_q;
`else
  assign addr_fault = (state_q == S_RESP) & flt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned WS   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef DMEM_STICKY_FAULT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_addr, data_out, data_in;
  logic        data_read, data_write, data_valid, data_busy, addr_fault;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .data_addr(data_addr), .data_out(data_out),
    .data_read(data_read), .data_write(data_write), .data_in(data_in),
    .data_valid(data_valid), .data_busy(data_busy), .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Reference model: RAM image, last read data, sticky fault flag.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_din = 32'd0;
  bit          sticky  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input bit rd, input bit wr, input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (a < BASE) || (off >= 32'd4096) || (rd && wr);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off[9:0]);
  endfunction

  // Issue one request at a negedge and follow it through its response.
  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    bit flt;
    int k;
    flt = is_fault(rd, wr, a);
    data_read = rd; data_write = wr; data_addr = a; data_out = wd;
    @(posedge clk); #1;
    data_read = 1'b0; data_write = 1'b0;
    k = 1;
    @(negedge clk);
    while (!data_valid && k < 20) begin
      chk("busy_wait", 32'(data_busy), 32'd1);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), flt ? 32'd1 : 32'(WS + 1));
    chk("valid", 32'(data_valid), 32'd1);
    chk("busy_resp", 32'(data_busy), 32'd1);
    if (flt) sticky = 1'b1;
    chk("fault", 32'(addr_fault), 32'(STICKY ? sticky : flt));
    if (!flt && rd) exp_din = ref_mem[widx(a)];
    chk("data_in", data_in, exp_din);
    if (!flt && wr) ref_mem[widx(a)] = wd;
    @(negedge clk);
    chk("valid_drop", 32'(data_valid), 32'd0);
    chk("busy_drop", 32'(data_busy), 32'd0);
    chk("fault_after", 32'(addr_fault), 32'(STICKY ? sticky : 1'b0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_din"}, data_in, 32'd0);
    chk({tag, "_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_busy"}, 32'(data_busy), 32'd0);
    chk({tag, "_fault"}, 32'(addr_fault), 32'd0);
  endtask

  initial begin
    int k, cnt, sel, asel, ix;
    bit rd, wr;
    logic [31:0] a;

    reset = 1'b0; data_read = 1'b1; data_write = 1'b0;
    data_addr = 32'h10; data_out = 32'd0;

    // Reset held for three cycles with a read request asserted.
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    data_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Write then read back with wait states.
    req(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    req(1'b1, 1'b0, 32'h10, 32'h0);
    chk("readback", data_in, 32'hCAFE_F00D);

    // Misaligned and out-of-range reads; data_in must hold.
    req(1'b1, 1'b0, 32'h12, 32'h0);
    req(1'b1, 1'b0, 32'h1000, 32'h0);
    req(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);

    // Top word of the RAM is legal.
    req(1'b0, 1'b1, 32'hFFC, 32'h0BAD_F00D);
    req(1'b1, 1'b0, 32'hFFC, 32'h0);

    // Simultaneous read+write faults and must not write.
    req(1'b0, 1'b1, 32'h20, 32'h0000_1234);
    req(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 32'h20, 32'h0);

    // Reset during WAIT aborts the write.
    req(1'b0, 1'b1, 32'h40, 32'h1111_1111);
    data_write = 1'b1; data_addr = 32'h40; data_out = 32'hAAAA_5555;
    @(posedge clk); #1;
    data_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_wait");
    reset = 1'b1; exp_din = 32'd0; sticky = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 32'h40, 32'h0);

    // Reset during the RESP cycle also aborts the write.
    req(1'b0, 1'b1, 32'h44, 32'h2222_2222);
    data_write = 1'b1; data_addr = 32'h44; data_out = 32'hBBBB_BBBB;
    @(posedge clk); #1;
    data_write = 1'b0;
    k = 1;
    @(negedge clk);
    while (!data_valid && k < 20) begin @(negedge clk); k++; end
    chk("rst_resp_lat", 32'(k), 32'(WS + 1));
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst_resp");
    reset = 1'b1; exp_din = 32'd0; sticky = 1'b0;
    @(negedge clk);
    req(1'b1, 1'b0, 32'h44, 32'h0);

    // Pre-load a pool of words for the random phase.
    for (int i = 0; i < 20; i++) begin
      ix = (i < 16) ? i : 1004 + i;
      req(1'b0, 1'b1, 32'(ix * 4), $urandom);
    end

    // Request held through a busy access: only one response.
    data_read = 1'b1; data_addr = 32'h10;
    @(posedge clk); #1;
    data_addr = 32'h14;
    k = 1;
    @(negedge clk);
    while (!data_valid && k < 20) begin @(negedge clk); k++; end
    data_read = 1'b0;
    chk("busy_lat", 32'(k), 32'(WS + 1));
    exp_din = ref_mem[4];
    chk("busy_data", data_in, exp_din);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_valid) cnt++;
    end
    chk("busy_extra_valid", 32'(cnt), 32'd0);

    // Fault followed by a legal read.
    req(1'b1, 1'b0, 32'h12, 32'h0);
    req(1'b1, 1'b0, 32'h8, 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 9);
      asel = $urandom_range(0, 9);
      rd = (sel <= 3) || (sel >= 8);
      wr = (sel >= 4) && (sel <= 8);
      ix = $urandom_range(0, 19);
      ix = (ix < 16) ? ix : 1004 + ix;
      if (asel <= 6)      a = 32'(ix * 4);
      else if (asel == 7) a = 32'(ix * 4) + 32'($urandom_range(1, 3));
      else if (asel == 8) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      else                a = 32'hFFFF_FFFC;
      req(rd, wr, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
